trap_sequencer: RTL

TRAP_SEQUENCER -- requirements
Module: trap_sequencer

---
 rtl/trap_sequencer_pkg.sv | 41 ++++
 rtl/trap_sequencer_arbiter.sv | 62 ++++++
 rtl/trap_sequencer.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/trap_sequencer_pkg.sv
// Shared definitions for the trap sequencer: FSM states, CSR addresses,
// interrupt cause codes and the mstatus/mie bit positions it touches.
package trap_sequencer_pkg;

  // Sequencer states. Encodings 6 and 7 are unused and recover to IDLE.
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_W_MEPC    = 3'd1,
    S_W_MCAUSE  = 3'd2,
    S_W_MTVAL   = 3'd3,
    S_W_MSTATUS = 3'd4,
    S_W_MRET    = 3'd5
  } state_e;

  // Machine-mode CSR addresses written by the sequencer.
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  // Interrupt cause codes (the interrupt flag lives in mcause[XLEN-1]).
  localparam int unsigned CAUSE_MSI = 3;
  localparam int unsigned CAUSE_MTI = 7;
  localparam int unsigned CAUSE_MEI = 11;

  // mstatus bit positions.
  localparam int unsigned MSTATUS_MIE    = 3;
  localparam int unsigned MSTATUS_MPIE   = 7;
  localparam int unsigned MSTATUS_MPP_LO = 11;

  // mie enable bit positions.
  localparam int unsigned MIE_MSIE = 3;
  localparam int unsigned MIE_MTIE = 7;
  localparam int unsigned MIE_MEIE = 11;

  // Positions inside the irq_i bundle {meip, mtip, msip}.
  localparam int unsigned IRQ_MSIP = 0;
  localparam int unsigned IRQ_MTIP = 1;
  localparam int unsigned IRQ_MEIP = 2;

endpackage

// File: rtl/trap_sequencer_arbiter.sv
// Combinational trap selection: the oldest (highest-index) faulting stage
// wins among exceptions; otherwise the highest-priority enabled interrupt
// (MEI > MSI > MTI) is chosen.
module trap_arbiter
  import trap_sequencer_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int NSRC = 3,
  parameter int CW   = 4
) (
  input  logic [NSRC-1:0]      exc_valid_i,
  input  logic [NSRC*CW-1:0]   exc_cause_i,
  input  logic [NSRC*XLEN-1:0] exc_pc_i,
  input  logic [NSRC*XLEN-1:0] exc_tval_i,
  input  logic [2:0]           irq_i,
  input  logic [2:0]           irq_en_i,
  input  logic                 mstatus_mie_i,
  input  logic [XLEN-1:0]      irq_pc_i,
  output logic                 take_exc_o,
  output logic                 take_irq_o,
  output logic [CW-1:0]        cause_o,
  output logic [XLEN-1:0]      pc_o,
  output logic [XLEN-1:0]      tval_o
);

  logic [2:0] irq_live;

  // Pick the winning trap source and its cause/pc/tval.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    take_exc_o = 1'b0;
    take_irq_o = 1'b0;
    cause_o    = '0;
    pc_o       = '0;
    tval_o     = '0;
    irq_live   = irq_i & irq_en_i & {3{mstatus_mie_i}};

    // Ascending scan: a later (older) stage overrides a younger one.
    for (int k = 0; k < NSRC; k++) begin
      if (exc_valid_i[k]) begin
        take_exc_o = 1'b1;
        cause_o    = exc_cause_i[k*CW +: CW];
        pc_o       = exc_pc_i[k*XLEN +: XLEN];
        tval_o     = exc_tval_i[k*XLEN +: XLEN];
      end
    end

    if (!take_exc_o && (irq_live != 3'b000)) begin
      take_irq_o = 1'b1;
      pc_o       = irq_pc_i;
      if (irq_live[IRQ_MEIP]) begin
        cause_o = CW'(CAUSE_MEI);
      end else if (irq_live[IRQ_MSIP]) begin
        cause_o = CW'(CAUSE_MSI);
      end else begin
        cause_o = CW'(CAUSE_MTI);
      end
    end
  end

endmodule

// File: rtl/trap_sequencer.sv
// Machine-mode trap sequencer: on an exception, interrupt or MRET it
// redirects the front end and then writes the trap CSRs one per cycle
// while holding the pipeline via busy_o.
module trap_sequencer
  import trap_sequencer_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int NSRC = 3,
  parameter int CW   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NSRC-1:0]      exc_valid_i,
  input  logic [NSRC*CW-1:0]   exc_cause_i,
  input  logic [NSRC*XLEN-1:0] exc_pc_i,
  input  logic [NSRC*XLEN-1:0] exc_tval_i,
  input  logic                 mret_i,
  input  logic [XLEN-1:0]      irq_pc_i,
  input  logic [2:0]           irq_i,
  input  logic [XLEN-1:0]      csr_mstatus_i,
  input  logic [XLEN-1:0]      csr_mie_i,
  input  logic [XLEN-1:0]      csr_mtvec_i,
  input  logic [XLEN-1:0]      csr_mepc_i,
  output logic                 csr_we_o,
  output logic [11:0]          csr_addr_o,
  output logic [XLEN-1:0]      csr_wdata_o,
  output logic                 redirect_o,
  output logic [XLEN-1:0]      redirect_addr_o,
  output logic                 busy_o
);

  state_e            state_q, state_d;
  logic [CW-1:0]     cause_q, cause_d;
  logic [XLEN-1:0]   tval_q, tval_d;
  logic              intr_q, intr_d;
  logic              csr_we_q, csr_we_d;
  logic [11:0]       csr_addr_q, csr_addr_d;
  logic [XLEN-1:0]   csr_wdata_q, csr_wdata_d;
  logic              redirect_q, redirect_d;
  logic [XLEN-1:0]   redirect_addr_q, redirect_addr_d;
  logic              busy_q, busy_d;

  logic              take_exc, take_irq;
  logic [CW-1:0]     arb_cause;
  logic [XLEN-1:0]   arb_pc, arb_tval;
  logic [XLEN-1:0]   trap_target, mcause_val, mstatus_trap, mstatus_mret;

  // Only the MEIE/MTIE/MSIE bits of mie matter to the sequencer.
  logic unused_mie_bits;
  assign unused_mie_bits = ^csr_mie_i;

  trap_arbiter #(
    .XLEN (XLEN),
    .NSRC (NSRC),
    .CW   (CW)
  ) u_arbiter (
    .exc_valid_i   (exc_valid_i),
    .exc_cause_i   (exc_cause_i),
    .exc_pc_i      (exc_pc_i),
    .exc_tval_i    (exc_tval_i),
    .irq_i         (irq_i),
    .irq_en_i      ({csr_mie_i[MIE_MEIE], csr_mie_i[MIE_MTIE], csr_mie_i[MIE_MSIE]}),
    .mstatus_mie_i (csr_mstatus_i[MSTATUS_MIE]),
    .irq_pc_i      (irq_pc_i),
    .take_exc_o    (take_exc),
    .take_irq_o    (take_irq),
    .cause_o       (arb_cause),
    .pc_o          (arb_pc),
    .tval_o        (arb_tval)
  );

  // Derived values: trap vector, mcause word and the two mstatus updates.
  always_comb begin
    trap_target = {csr_mtvec_i[XLEN-1:2], 2'b00};
    if (take_irq && (csr_mtvec_i[1:0] == 2'b01)) begin
      trap_target = trap_target + {{(XLEN-CW-2){1'b0}}, arb_cause, 2'b00};
    end

    mcause_val = {intr_q, {(XLEN-1-CW){1'b0}}, cause_q};

    mstatus_trap                           = csr_mstatus_i;
    mstatus_trap[MSTATUS_MPIE]             = csr_mstatus_i[MSTATUS_MIE];
    mstatus_trap[MSTATUS_MIE]              = 1'b0;
    mstatus_trap[MSTATUS_MPP_LO +: 2]      = 2'b11;

    mstatus_mret                           = csr_mstatus_i;
    mstatus_mret[MSTATUS_MIE]              = csr_mstatus_i[MSTATUS_MPIE];
    mstatus_mret[MSTATUS_MPIE]             = 1'b1;
    mstatus_mret[MSTATUS_MPP_LO +: 2]      = 2'b00;
  end

  // Next state, trap latches and the next value of every registered output.
  always_comb begin
    state_d         = state_q;
    cause_d         = cause_q;
    tval_d          = tval_q;
    intr_d          = intr_q;
    csr_we_d        = 1'b0;
    csr_addr_d      = '0;
    csr_wdata_d     = '0;
    redirect_d      = 1'b0;
    redirect_addr_d = redirect_addr_q;

    case (state_q)
      S_IDLE: begin
        if (take_exc || take_irq) begin
          state_d         = S_W_MEPC;
          cause_d         = arb_cause;
          tval_d          = take_irq ? '0 : arb_tval;
          intr_d          = take_irq;
          csr_we_d        = 1'b1;
          csr_addr_d      = CSR_MEPC;
          csr_wdata_d     = arb_pc;
          redirect_d      = 1'b1;
          redirect_addr_d = trap_target;
        end else if (mret_i) begin
          state_d         = S_W_MRET;
          csr_we_d        = 1'b1;
          csr_addr_d      = CSR_MSTATUS;
          csr_wdata_d     = mstatus_mret;
          redirect_d      = 1'b1;
          redirect_addr_d = csr_mepc_i;
        end
      end
      S_W_MEPC: begin
        state_d     = S_W_MCAUSE;
        csr_we_d    = 1'b1;
        csr_addr_d  = CSR_MCAUSE;
        csr_wdata_d = mcause_val;
      end
      S_W_MCAUSE: begin
        state_d     = S_W_MTVAL;
        csr_we_d    = 1'b1;
        csr_addr_d  = CSR_MTVAL;
        csr_wdata_d = tval_q;
      end
      S_W_MTVAL: begin
        state_d     = S_W_MSTATUS;
        csr_we_d    = 1'b1;
        csr_addr_d  = CSR_MSTATUS;
        csr_wdata_d = mstatus_trap;
      end
      S_W_MSTATUS: state_d = S_IDLE;
      S_W_MRET:    state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State, trap latches and output registers; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      cause_q         <= '0;
      tval_q          <= '0;
      intr_q          <= 1'b0;
      csr_we_q        <= 1'b0;
      csr_addr_q      <= '0;
      csr_wdata_q     <= '0;
      redirect_q      <= 1'b0;
      redirect_addr_q <= '0;
      busy_q          <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values computed above, independent of statement order.
      state_q         <= state_d;
      cause_q         <= cause_d;
      tval_q          <= tval_d;
      intr_q          <= intr_d;
      csr_we_q        <= csr_we_d;
      csr_addr_q      <= csr_addr_d;
      csr_wdata_q     <= csr_wdata_d;
      redirect_q      <= redirect_d;
      redirect_addr_q <= redirect_addr_d;
      busy_q          <= busy_d;
    end
  end

  assign csr_we_o        = csr_we_q;
  assign csr_addr_o      = csr_addr_q;
  assign csr_wdata_o     = csr_wdata_q;
  assign redirect_o      = redirect_q;
  assign redirect_addr_o = redirect_addr_q;
  assign busy_o          = busy_q;

endmodule
